// File: rtl/int_issue_if.sv
// Issue-queue state in, integer issue slot and entry-free mask out, for the integer select stage.
interface int_issue_if #(
    parameter int QUEUE_SIZE = 8,
    parameter int IDX_W      = 3,
    parameter int AL_ID_W    = 6
);
    logic [QUEUE_SIZE-1:0]         entry_valid;
    logic [QUEUE_SIZE-1:0]         src1_ready;
    logic [QUEUE_SIZE-1:0]         src2_ready;
    logic [QUEUE_SIZE-1:0]         alloc_mask;
    logic [QUEUE_SIZE*AL_ID_W-1:0] entry_al_id;
    logic                          flush;
    logic                          alu_ready;

    logic                          issue_valid;
    logic [IDX_W-1:0]              issue_index;
    logic [AL_ID_W-1:0]            issue_al_id;
    logic [QUEUE_SIZE-1:0]         clear_mask;
    logic [31:0]                   issue_count;

    modport master (
        output entry_valid, src1_ready, src2_ready, alloc_mask, entry_al_id, flush, alu_ready,
        input  issue_valid, issue_index, issue_al_id, clear_mask, issue_count
    );

    modport slave (
        input  entry_valid, src1_ready, src2_ready, alloc_mask, entry_al_id, flush, alu_ready,
        output issue_valid, issue_index, issue_al_id, clear_mask, issue_count
    );
endinterface

// File: rtl/int_issue_select.sv
// Oldest-ready select for the integer issue queue: age matrix, one-deep issue slot toward the ALU,
// and the one-hot free mask returned to the queue owner when the ALU takes the op.
module int_issue_select #(
    parameter int QUEUE_SIZE = 8,
    parameter int IDX_W      = 3,
    parameter int AL_ID_W    = 6
) (
    input logic        clk,
    input logic        rst_n,
    int_issue_if.slave bus
);

    logic [QUEUE_SIZE-1:0] older_q [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] older_d [QUEUE_SIZE];

    logic                  issue_valid_q;
    logic [IDX_W-1:0]      issue_index_q;
    logic [AL_ID_W-1:0]    issue_al_id_q;
    logic [31:0]           issue_count_q;

    logic                  accept;
    logic [QUEUE_SIZE-1:0] cand;
    logic [QUEUE_SIZE-1:0] win;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_index;
    logic [AL_ID_W-1:0]    sel_al_id;
    logic [QUEUE_SIZE-1:0] clear_mask;

    // A flush or reset cycle never retires the slot, so nothing is freed or counted.
    assign accept = issue_valid_q & bus.alu_ready & rst_n & ~bus.flush;

    // Each new entry becomes younger than every entry already valid; a pair allocated
    // together is ordered by index.
    always_comb begin
        // NOTE: every always_comb output takes a default first so no path can infer a latch.
        older_d = older_q;
        for (int k = 0; k < QUEUE_SIZE; k++) begin
            if (bus.alloc_mask[k]) begin
                older_d[k] = '0;
                for (int j = 0; j < QUEUE_SIZE; j++) begin
                    if (!bus.alloc_mask[j]) begin
                        older_d[j][k] = bus.entry_valid[j];
                    end else if (j > k) begin
                        older_d[k][j] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cand       = '0;
        win        = '0;
        sel_valid  = 1'b0;
        sel_index  = '0;
        sel_al_id  = '0;
        clear_mask = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            cand[i] = bus.entry_valid[i] & bus.src1_ready[i] & bus.src2_ready[i]
                    & ~(issue_valid_q && issue_index_q == IDX_W'(i))
                    & ~bus.alloc_mask[i];
            clear_mask[i] = accept && issue_index_q == IDX_W'(i);
        end
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < QUEUE_SIZE; j++) begin
                if (j != i && cand[j] && older_q[j][i]) win[i] = 1'b0;
            end
        end
        // Walking downward leaves the lowest-index winner if the matrix ever disagrees.
        for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
            if (win[i]) begin
                sel_valid = 1'b1;
                sel_index = IDX_W'(i);
                sel_al_id = bus.entry_al_id[i*AL_ID_W +: AL_ID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the age matrix is control state read by select, so unlike a data array it is reset.
        if (!rst_n || bus.flush) begin
            older_q <= '{default: '0};
        end else begin
            older_q <= older_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            issue_al_id_q <= '0;
            issue_count_q <= '0;
        end else begin
            if (accept) issue_count_q <= issue_count_q + 32'd1;
            if (bus.flush) begin
                issue_valid_q <= 1'b0;
            end else if (!issue_valid_q || accept) begin
                issue_valid_q <= sel_valid;
                if (sel_valid) begin
                    issue_index_q <= sel_index;
                    issue_al_id_q <= sel_al_id;
                end
            end
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_index = issue_index_q;
    assign bus.issue_al_id = issue_al_id_q;
    assign bus.clear_mask  = clear_mask;
    assign bus.issue_count = issue_count_q;

endmodule

// File: tb/tb_int_issue_select.sv
// Bench for int_issue_select: directed scenarios plus random traffic, all against an
// allocation-timestamp model of program order and a behavioural issue slot.
module tb_int_issue_select;
    localparam int QS = 8;
    localparam int IW = 3;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int_issue_if #(.QUEUE_SIZE(QS), .IDX_W(IW), .AL_ID_W(AW)) bus ();

    int_issue_select #(.QUEUE_SIZE(QS), .IDX_W(IW), .AL_ID_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Queue owner state driven into the DUT.
    logic [QS-1:0] ev;
    logic [QS-1:0] r1;
    logic [QS-1:0] r2;
    logic [AW-1:0] alid [QS];
    logic [QS-1:0] alloc_v;
    bit            flush_v;
    bit            alu_rdy;

    // Reference model: program order is the allocation sequence number.
    int unsigned   stamp [QS];
    int unsigned   stamp_ctr;
    bit            m_v;
    int            m_idx;
    logic [AW-1:0] m_al;
    int unsigned   m_cnt;
    logic [QS-1:0] last_clear;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        bus.entry_valid = ev;
        bus.src1_ready  = r1;
        bus.src2_ready  = r2;
        bus.alloc_mask  = alloc_v;
        bus.flush       = flush_v;
        bus.alu_ready   = alu_rdy;
        for (int i = 0; i < QS; i++) bus.entry_al_id[i*AW +: AW] = alid[i];
    endtask

    task automatic alloc_entry(input int k, input bit a, input bit b);
        alloc_v[k] = 1'b1;
        r1[k]      = a;
        r2[k]      = b;
        alid[k]    = AW'($urandom);
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        logic [QS-1:0] expc;
        bit            acc;
        int            win;
        drive_bus();
        #1;
        check("issue_valid", 64'(bus.issue_valid), 64'(m_v));
        if (m_v) begin
            check("issue_index", 64'(bus.issue_index), 64'(m_idx));
            check("issue_al_id", 64'(bus.issue_al_id), 64'(m_al));
        end
        check("issue_count", 64'(bus.issue_count), 64'(m_cnt));
        acc  = m_v && alu_rdy && !flush_v;
        expc = '0;
        if (acc) expc[m_idx] = 1'b1;
        check("clear_mask", 64'(bus.clear_mask), 64'(expc));
        last_clear = bus.clear_mask;

        win = -1;
        for (int i = 0; i < QS; i++) begin
            if (ev[i] && r1[i] && r2[i] && !(m_v && m_idx == i) && !alloc_v[i]) begin
                if (win < 0 || stamp[i] < stamp[win]) win = i;
            end
        end

        @(posedge clk);
        if (flush_v) begin
            m_v = 1'b0;
            ev  = '0;
        end else begin
            if (acc) m_cnt++;
            if (!m_v || acc) begin
                m_v = (win >= 0);
                if (win >= 0) begin
                    m_idx = win;
                    m_al  = alid[win];
                end
            end
            for (int k = 0; k < QS; k++) begin
                if (alloc_v[k]) begin
                    stamp_ctr++;
                    stamp[k] = stamp_ctr;
                end
            end
            ev = (ev & ~expc) | alloc_v;
        end
        alloc_v = '0;
        flush_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        alu_rdy = 1'b1;
        alloc_v = '0;
        flush_v = 1'b0;
        drive_bus();
        #1;
        check("rst_clear_mask", 64'(bus.clear_mask), 64'(0));
        @(posedge clk);
        ev    = '0;
        r1    = '0;
        r2    = '0;
        m_v   = 1'b0;
        m_idx = 0;
        m_al  = '0;
        m_cnt = 0;
        for (int i = 0; i < QS; i++) stamp[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_issue_valid", 64'(bus.issue_valid), 64'(0));
        check("rst_issue_index", 64'(bus.issue_index), 64'(0));
        check("rst_issue_al_id", 64'(bus.issue_al_id), 64'(0));
        check("rst_issue_count", 64'(bus.issue_count), 64'(0));
    endtask

    initial begin
        stamp_ctr = 0;
        ev        = '0;
        r1        = '0;
        r2        = '0;
        alloc_v   = '0;
        flush_v   = 1'b0;
        alu_rdy   = 1'b1;
        for (int i = 0; i < QS; i++) alid[i] = '0;
        @(negedge clk);
        do_reset();

        // Same-cycle pair: the lower index is older.
        alu_rdy = 1'b1;
        alloc_entry(2, 1, 1);
        alloc_entry(5, 1, 1);
        step();
        step();
        check("t1_first_index", 64'(bus.issue_index), 64'(2));
        step();
        check("t1_clear_2", 64'(last_clear), 64'(8'h04));
        check("t1_second_index", 64'(bus.issue_index), 64'(5));
        step();
        check("t1_clear_5", 64'(last_clear), 64'(8'h20));
        check("t1_count", 64'(bus.issue_count), 64'(2));

        // Age beats index.
        do_reset();
        alloc_entry(6, 0, 0);
        step();
        alloc_entry(1, 0, 0);
        step();
        step();
        step();
        r1[6] = 1'b1; r2[6] = 1'b1; r1[1] = 1'b1; r2[1] = 1'b1;
        step();
        check("t2_older_first", 64'(bus.issue_index), 64'(6));
        step();
        check("t2_younger_next", 64'(bus.issue_index), 64'(1));

        // Stall holds the slot.
        do_reset();
        alu_rdy = 1'b0;
        alloc_entry(3, 1, 1);
        alloc_entry(4, 1, 0);
        step();
        step();
        r2[4] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t3_stall_clear", 64'(last_clear), 64'(0));
            check("t3_stall_index", 64'(bus.issue_index), 64'(3));
        end
        alu_rdy = 1'b1;
        step();
        check("t3_accept_clear", 64'(last_clear), 64'(8'h08));
        check("t3_next_index", 64'(bus.issue_index), 64'(4));

        // Flush kills the slot and the age state.
        do_reset();
        alu_rdy = 1'b0;
        alloc_entry(7, 1, 1);
        alloc_entry(1, 0, 0);
        step();
        alloc_entry(2, 0, 0);
        alloc_entry(3, 0, 0);
        step();
        alloc_entry(4, 0, 0);
        step();
        check("t4_slot_7", 64'(bus.issue_index), 64'(7));
        alu_rdy = 1'b1;
        flush_v = 1'b1;
        step();
        check("t4_flush_clear", 64'(last_clear), 64'(0));
        check("t4_flush_valid", 64'(bus.issue_valid), 64'(0));
        alloc_entry(0, 1, 1);
        step();
        check("t4_no_clear_7", 64'(last_clear[7]), 64'(0));
        step();
        check("t4_realloc_index", 64'(bus.issue_index), 64'(0));

        // Full queue, nothing ready, then a single entry wakes.
        do_reset();
        alu_rdy = 1'b0;
        for (int p = 0; p < QS; p += 2) begin
            alloc_entry(p, 1, 0);
            alloc_entry(p + 1, 1, 0);
            step();
        end
        for (int c = 0; c < 10; c++) begin
            step();
            check("t5_full_idle", 64'(bus.issue_valid), 64'(0));
        end
        r2[5] = 1'b1;
        step();
        step();
        check("t5_wake_valid", 64'(bus.issue_valid), 64'(1));
        check("t5_wake_index", 64'(bus.issue_index), 64'(5));

        // Reset with a stalled op in the slot after one accepted issue.
        do_reset();
        alu_rdy = 1'b1;
        alloc_entry(2, 1, 1);
        step();
        step();
        step();
        check("t6_count_before", 64'(bus.issue_count), 64'(1));
        alu_rdy = 1'b0;
        alloc_entry(3, 1, 1);
        step();
        step();
        step();
        check("t6_stalled_index", 64'(bus.issue_index), 64'(3));
        do_reset();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int n;
            int off;
            alu_rdy = ($urandom_range(3) != 0);
            flush_v = ($urandom_range(63) == 0);
            for (int i = 0; i < QS; i++) begin
                if (ev[i] && $urandom_range(3) == 0) r1[i] = 1'b1;
                if (ev[i] && $urandom_range(3) == 0) r2[i] = 1'b1;
            end
            if (!flush_v) begin
                n   = $urandom_range(2);
                off = $urandom_range(QS - 1);
                for (int i = 0; i < QS; i++) begin
                    int k;
                    k = (off + i) % QS;
                    if (n > 0 && !ev[k]) begin
                        alloc_entry(k, 1'($urandom_range(1)), 1'($urandom_range(1)));
                        n--;
                    end
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
